// File: rtl/memory_pkg.sv
// Shared types and constants for multiport_memory and its per-port controller.
// Covers both builds: default full-line writes, and MEM_BYTE_MASK_EN byte-strobed writes.
package memory_pkg;

    localparam int WORD_BITS = 32;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } port_state_e;

endpackage

// File: rtl/memory_port_ctrl.sv
// One request port: accepts a read or write in IDLE, holds the request for LATENCY cycles.
// With MEM_BYTE_MASK_EN the write strobes are latched alongside the data.
//
// state | meaning
// IDLE  | waiting; a read (preferred) or write request is latched on the next edge
// READ  | read in flight, counting down to its completion edge
// WRITE | write in flight, counting down to its commit edge
module memory_port_ctrl
    import memory_pkg::*;
#(
    parameter int IDX_W     = 11,
    parameter int LINE_BITS = 128,
    parameter int LATENCY   = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   read_en_i,
    input  logic                   write_en_i,
    input  logic [31:0]            addr_i,
    input  logic [LINE_BITS-1:0]   wdata_i,
`ifdef MEM_BYTE_MASK_EN
    input  logic [LINE_BITS/8-1:0] byte_en_i,
    output logic [LINE_BITS/8-1:0] byte_en_o,
`endif
    output logic [IDX_W-1:0]       idx_o,
    output logic [LINE_BITS-1:0]   wdata_o,
    output logic                   rd_done_o,
    output logic                   wr_done_o,
    output logic                   ready_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    port_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LINE_BITS-1:0]   wdata_q, wdata_d;
    logic                   ready_q;
    logic                   done;
`ifdef MEM_BYTE_MASK_EN
    logic [LINE_BITS/8-1:0] be_q, be_d;
`endif

    // Byte offset and address bits above the array size carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    assign done = (state_q != IDLE) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
`ifdef MEM_BYTE_MASK_EN
        be_d    = be_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (read_en_i) begin
                    state_d = READ;
                    cnt_d   = CNT_LOAD;
                    idx_d   = addr_i[IDX_W+1:2];
                end else if (write_en_i) begin
                    state_d = WRITE;
                    cnt_d   = CNT_LOAD;
                    idx_d   = addr_i[IDX_W+1:2];
                    wdata_d = wdata_i;
`ifdef MEM_BYTE_MASK_EN
                    be_d    = byte_en_i;
`endif
                end
            end
            READ, WRITE: begin
                if (done) state_d = IDLE;
                else      cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
`ifdef MEM_BYTE_MASK_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ready_q <= done;
`ifdef MEM_BYTE_MASK_EN
            be_q    <= be_d;
`endif
        end
    end

    assign idx_o     = idx_q;
    assign wdata_o   = wdata_q;
    assign rd_done_o = done && (state_q == READ);
    assign wr_done_o = done && (state_q == WRITE);
    assign ready_o   = ready_q;
`ifdef MEM_BYTE_MASK_EN
    assign byte_en_o = be_q;
`endif

endmodule

// File: rtl/multiport_memory.sv
// Shared word array with NUM_PORTS independent fixed-latency line ports; lowest port wins write clashes.
// Define MEM_BYTE_MASK_EN to add per-byte write strobes (in_byte_en).
module multiport_memory
    import memory_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int MEM_WORDS  = 2048,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 10
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_PORTS-1:0]                          in_read_en,
    input  logic [NUM_PORTS-1:0]                          in_write_en,
    input  logic [NUM_PORTS-1:0][31:0]                    in_addr,
    input  logic [NUM_PORTS-1:0][LINE_WORDS*WORD_BITS-1:0] in_write_data,
`ifdef MEM_BYTE_MASK_EN
    input  logic [NUM_PORTS-1:0][LINE_WORDS*4-1:0]        in_byte_en,
`endif
    output logic [NUM_PORTS-1:0][LINE_WORDS*WORD_BITS-1:0] out_read_data,
    output logic [NUM_PORTS-1:0]                          out_ready
);

    localparam int LINE_BITS = LINE_WORDS * WORD_BITS;
    localparam int IDX_W     = $clog2(MEM_WORDS);

    logic [WORD_BITS-1:0]                mem_q [MEM_WORDS];
    logic [NUM_PORTS-1:0][IDX_W-1:0]     idx;
    logic [NUM_PORTS-1:0][LINE_BITS-1:0] wdata;
    logic [NUM_PORTS-1:0][LINE_BITS-1:0] rdata_q;
    logic [NUM_PORTS-1:0]                rd_done;
    logic [NUM_PORTS-1:0]                wr_done;
`ifdef MEM_BYTE_MASK_EN
    logic [NUM_PORTS-1:0][LINE_WORDS*4-1:0] be;
`endif

    // Truncation to IDX_W bits gives the wrap at the top of memory.
    function automatic logic [IDX_W-1:0] line_word(input logic [IDX_W-1:0] base, input int k);
        return base + IDX_W'(k);
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        memory_port_ctrl #(
            .IDX_W     (IDX_W),
            .LINE_BITS (LINE_BITS),
            .LATENCY   (LATENCY)
        ) u_ctrl (
            .clk        (clk),
            .reset      (reset),
            .read_en_i  (in_read_en[p]),
            .write_en_i (in_write_en[p]),
            .addr_i     (in_addr[p]),
            .wdata_i    (in_write_data[p]),
`ifdef MEM_BYTE_MASK_EN
            .byte_en_i  (in_byte_en[p]),
            .byte_en_o  (be[p]),
`endif
            .idx_o      (idx[p]),
            .wdata_o    (wdata[p]),
            .rd_done_o  (rd_done[p]),
            .wr_done_o  (wr_done[p]),
            .ready_o    (out_ready[p])
        );
    end

    // Array keeps its contents through reset; ports are walked high to low so port 0 lands last.
    always_ff @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (wr_done[p]) begin
                for (int k = 0; k < LINE_WORDS; k++) begin
`ifdef MEM_BYTE_MASK_EN
                    for (int b = 0; b < 4; b++) begin
                        if (be[p][4*k+b])
                            mem_q[line_word(idx[p], k)][8*b +: 8] <= wdata[p][k*WORD_BITS+8*b +: 8];
                    end
`else
                    mem_q[line_word(idx[p], k)] <= wdata[p][k*WORD_BITS +: WORD_BITS];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_done[p]) begin
                    for (int k = 0; k < LINE_WORDS; k++)
                        rdata_q[p][k*WORD_BITS +: WORD_BITS] <= mem_q[line_word(idx[p], k)];
                end
            end
        end
    end

    assign out_read_data = rdata_q;

endmodule

// File: tb/tb_multiport_memory.sv
// Directed and randomized bench for multiport_memory against a word-array reference model.
// Builds with or without MEM_BYTE_MASK_EN.
`timescale 1ns/1ps
module tb_multiport_memory;

    localparam int NP  = 2;
    localparam int MW  = 2048;
    localparam int LW  = 4;
    localparam int LAT = 10;
    localparam int LB  = LW * 32;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NP-1:0]           rd_en;
    logic [NP-1:0]           wr_en;
    logic [NP-1:0][31:0]     addr;
    logic [NP-1:0][LB-1:0]   wdata;
    logic [NP-1:0][LW*4-1:0] byte_en;
    logic [NP-1:0][LB-1:0]   rdata;
    logic [NP-1:0]           ready;

    logic [31:0]             ref_mem [MW];
    logic [NP-1:0][LB-1:0]   ref_rdata;
    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    multiport_memory #(
        .NUM_PORTS  (NP),
        .MEM_WORDS  (MW),
        .LINE_WORDS (LW),
        .LATENCY    (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_read_en    (rd_en),
        .in_write_en   (wr_en),
        .in_addr       (addr),
        .in_write_data (wdata),
`ifdef MEM_BYTE_MASK_EN
        .in_byte_en    (byte_en),
`endif
        .out_read_data (rdata),
        .out_ready     (ready)
    );

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LB-1:0] model_read(input logic [31:0] a);
        logic [LB-1:0] line;
        int base;
        base = int'(a >> 2);
        for (int k = 0; k < LW; k++) line[k*32 +: 32] = ref_mem[(base + k) % MW];
        return line;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [LB-1:0] d, input logic [LW*4-1:0] m);
        int base;
        base = int'(a >> 2);
        for (int k = 0; k < LW; k++)
            for (int b = 0; b < 4; b++)
                if (m[4*k+b]) ref_mem[(base + k) % MW][8*b +: 8] = d[32*k+8*b +: 8];
    endtask

    // Issue one request per selected port on the same edge and check completion.
    task automatic issue(input logic [NP-1:0] rd, input logic [NP-1:0] wr);
        logic [NP-1:0] act;
        logic          early;
        act = rd | wr;
        for (int p = 0; p < NP; p++)
            if (rd[p]) ref_rdata[p] = model_read(addr[p]);
        // Applying port 0 last lets it own any overlapping bytes.
        for (int p = NP - 1; p >= 0; p--)
            if (wr[p] && !rd[p]) model_write(addr[p], wdata[p], byte_en[p]);
        rd_en = rd;
        wr_en = wr;
        @(posedge clk); #1;
        rd_en = '0;
        wr_en = '0;
        early = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            @(posedge clk); #1;
            early = early | (|ready);
        end
        @(posedge clk); #1;
        check("no_early_ready", LB'(early), '0);
        check("ready_at_latency", LB'(ready), LB'(act));
        for (int p = 0; p < NP; p++) check($sformatf("rdata_p%0d", p), rdata[p], ref_rdata[p]);
        @(posedge clk); #1;
        check("ready_one_cycle", LB'(ready), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0] line_a, old_line, exp1, exp2;
        logic          seen;
        int            n;

        reset   = 1'b1;
        rd_en   = '0;
        wr_en   = '0;
        addr    = '0;
        wdata   = '0;
        byte_en = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", LB'(ready), '0);
        check("reset_rdata_p0", rdata[0], '0);
        check("reset_rdata_p1", rdata[1], '0);
        reset     = 1'b0;
        ref_rdata = '0;
        @(posedge clk); #1;

        // Zero the low 64 words and the top 8 words used by the random phase.
        for (int i = 0; i < 16; i += 2) begin
            addr[0] = 32'(i * 16);
            addr[1] = 32'((i + 1) * 16);
            issue('0, '1);
        end
        addr[0] = 32'h1FE0;
        addr[1] = 32'h1FF0;
        issue('0, '1);

        // Basic write then read-back.
        addr[0]  = 32'h100;
        wdata[0] = 128'h44443333_22221111_DEADBEEF_CAFEF00D;
        issue(2'b00, 2'b01);
        issue(2'b01, 2'b00);
        check("line_readback", rdata[0], 128'h44443333_22221111_DEADBEEF_CAFEF00D);

        // Line wrapping past the top of memory.
        line_a   = 128'h0404_0404_0303_0303_0202_0202_0101_0101;
        addr[0]  = 32'h1FF8;
        wdata[0] = line_a;
        issue(2'b00, 2'b01);
        addr[0] = 32'h0;
        issue(2'b01, 2'b00);
        check("wrap_low_half", {64'h0, rdata[0][63:0]}, {64'h0, line_a[127:64]});
        addr[0] = 32'h1FFB;
        issue(2'b01, 2'b00);
        check("wrap_full_line", rdata[0], line_a);

        // Same-edge write clash: port 0 wins.
        addr[0]  = 32'h200;
        addr[1]  = 32'h200;
        wdata[0] = {4{32'hAAAAAAAA}};
        wdata[1] = {4{32'h55555555}};
        issue(2'b00, 2'b11);
        issue(2'b10, 2'b00);
        check("prio_port0_wins", rdata[1], {4{32'hAAAAAAAA}});

        // Reset during a write aborts it.
        old_line    = model_read(32'h100);
        addr[0]     = 32'h100;
        wdata[0]    = {4{32'hBAD0BAD0}};
        wr_en[0]    = 1'b1;
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_rdata_cleared", rdata[0], '0);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            seen = seen | (|ready);
            @(posedge clk); #1;
        end
        check("abort_no_ready_in_reset", LB'(seen), '0);
        reset     = 1'b0;
        ref_rdata = '0;
        seen      = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            seen = seen | (|ready);
        end
        check("abort_no_ready_after", LB'(seen), '0);
        addr[0] = 32'h100;
        issue(2'b01, 2'b00);
        check("abort_kept_old", rdata[0], old_line);

        // Address change while busy is ignored; held request is taken in the ready cycle.
        exp1     = model_read(32'h100);
        exp2     = model_read(32'h200);
        addr[0]  = 32'h100;
        rd_en[0] = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!ready[0] && n < 3 * LAT) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) addr[0] = 32'h200;
        end
        check("busy_read_latency", LB'(n), LB'(LAT));
        check("busy_read_data", rdata[0], exp1);
        @(posedge clk); #1;
        rd_en[0] = 1'b0;
        check("b2b_pulse_end", LB'(ready[0]), '0);
        n = 0;
        while (!ready[0] && n < 3 * LAT) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_latency", LB'(n), LB'(LAT));
        check("b2b_data", rdata[0], exp2);
        ref_rdata[0] = exp2;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("no_queued_request", rdata[0], exp2);

`ifdef MEM_BYTE_MASK_EN
        addr[0]  = 32'h300;
        wdata[0] = '0;
        issue(2'b00, 2'b01);
        wdata[0]   = '1;
        byte_en[0] = 16'h0001;
        issue(2'b00, 2'b01);
        issue(2'b01, 2'b00);
        check("mask_byte0_only", rdata[0], 128'h000000FF);
        byte_en = '1;
`endif

        // Randomized traffic within the zeroed regions.
        for (int it = 0; it < 40; it++) begin
            logic [NP-1:0] r, w;
            int            sel, base;
            for (int p = 0; p < NP; p++) begin
                sel      = int'($urandom_range(0, 67));
                base     = (sel < 8) ? (2040 + sel) : (sel - 8);
                addr[p]  = 32'(base * 4) + 32'($urandom_range(0, 3));
                wdata[p] = {$urandom, $urandom, $urandom, $urandom};
`ifdef MEM_BYTE_MASK_EN
                byte_en[p] = 16'($urandom);
`endif
            end
            r = NP'($urandom);
            w = NP'($urandom);
            if ((r | w) == '0) w[0] = 1'b1;
            issue(r, w);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
